// File: rtl/lzw_stream_encoder.sv
// Streaming LZW encoder: one symbol per input handshake, fixed-width codes out.
// The dictionary is a linear (prefix, suffix) table scanned one entry per cycle.
module lzw_stream_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int CODE_WIDTH = 9,
  parameter int FULL_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CODE_WIDTH-1:0] out_code,
  output logic                  out_last,
  output logic                  dict_full,
  output logic                  busy
);

  // next_code and idx need one extra bit so they can hold 2^CODE_WIDTH (full).
  localparam int PTR_WIDTH  = CODE_WIDTH + 1;
  localparam int DICT_DEPTH = 1 << CODE_WIDTH;
  localparam logic [PTR_WIDTH-1:0] FIRST = PTR_WIDTH'(1) << DATA_WIDTH;
  localparam logic [PTR_WIDTH-1:0] LIMIT = PTR_WIDTH'(1) << CODE_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CHAR,
    SEARCH,
    EMIT,
    FINAL
  } state_t;

  state_t                state;
  logic [CODE_WIDTH-1:0] w;
  logic [DATA_WIDTH-1:0] c;
  logic [PTR_WIDTH-1:0]  next_code;
  logic [PTR_WIDTH-1:0]  idx;
  logic                  pend_last;

  // Entries below FIRST are never written; only FIRST..next_code-1 are live.
  logic [CODE_WIDTH-1:0] prefix_mem [DICT_DEPTH];
  logic [DATA_WIDTH-1:0] suffix_mem [DICT_DEPTH];

  logic                  accept;
  logic                  idx_live;
  logic                  hit;
  logic                  dict_we;
  logic [CODE_WIDTH-1:0] idx_addr;
  logic [CODE_WIDTH-1:0] ins_addr;
  logic [CODE_WIDTH-1:0] c_ext;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // out_valid/out_code/out_last hold until out_ready; cs gates in_ready only.
  assign in_ready  = cs && ((state == IDLE) || (state == WAIT_CHAR));
  assign accept    = in_valid && in_ready;
  assign dict_full = (next_code == LIMIT);
  assign busy      = (state != IDLE);

  assign idx_addr  = idx[CODE_WIDTH-1:0];
  assign ins_addr  = next_code[CODE_WIDTH-1:0];
  assign c_ext     = CODE_WIDTH'(c);
  assign idx_live  = (idx < next_code);
  assign hit       = idx_live && (prefix_mem[idx_addr] == w) && (suffix_mem[idx_addr] == c);
  assign dict_we   = (state == EMIT) && out_ready && !dict_full;

  always_ff @(posedge clk) begin
    if (dict_we) begin
      prefix_mem[ins_addr] <= w;
      suffix_mem[ins_addr] <= c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w         <= '0;
      c         <= '0;
      next_code <= FIRST;
      idx       <= FIRST;
      pend_last <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            w <= CODE_WIDTH'(in_data);
            if (in_last) begin
              out_valid <= 1'b1;
              out_code  <= CODE_WIDTH'(in_data);
              out_last  <= 1'b1;
              state     <= FINAL;
            end else begin
              state <= WAIT_CHAR;
            end
          end
        end

        WAIT_CHAR: begin
          if (accept) begin
            c         <= in_data;
            pend_last <= in_last;
            idx       <= FIRST;
            state     <= SEARCH;
          end
        end

        SEARCH: begin
          if (hit) begin
            w <= idx_addr;
            if (pend_last) begin
              out_valid <= 1'b1;
              out_code  <= idx_addr;
              out_last  <= 1'b1;
              state     <= FINAL;
            end else begin
              state <= WAIT_CHAR;
            end
          end else if (idx_live) begin
            idx <= idx + PTR_WIDTH'(1);
          end else begin
            out_valid <= 1'b1;
            out_code  <= w;
            out_last  <= 1'b0;
            state     <= EMIT;
          end
        end

        EMIT: begin
          if (out_ready) begin
            // Full dictionary either freezes or restarts; the decoder mirrors this.
            if (!dict_full) begin
              next_code <= next_code + PTR_WIDTH'(1);
            end else if (FULL_MODE != 0) begin
              next_code <= FIRST;
            end
            w <= c_ext;
            if (pend_last) begin
              out_code <= c_ext;
              out_last <= 1'b1;
              state    <= FINAL;
            end else begin
              out_valid <= 1'b0;
              state     <= WAIT_CHAR;
            end
          end
        end

        FINAL: begin
          if (out_ready) begin
            next_code <= FIRST;
            pend_last <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzw_stream_encoder.sv
// Directed bench for lzw_stream_encoder: default 8/9 instance plus two 2/3
// instances (freeze and restart on full), checked against hand-computed codes.
module tb_lzw_stream_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       cs;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;
  logic [1:0] sel;

  logic       d0_ready, d0_valid, d0_last, d0_full, d0_busy;
  logic [8:0] d0_code;
  logic       d1_ready, d1_valid, d1_last, d1_full, d1_busy;
  logic [2:0] d1_code;
  logic       d2_ready, d2_valid, d2_last, d2_full, d2_busy;
  logic [2:0] d2_code;

  logic v0, v1, v2, r0, r1, r2;
  assign v0 = in_valid && (sel == 2'd0);
  assign v1 = in_valid && (sel == 2'd1);
  assign v2 = in_valid && (sel == 2'd2);
  assign r0 = out_ready && (sel == 2'd0);
  assign r1 = out_ready && (sel == 2'd1);
  assign r2 = out_ready && (sel == 2'd2);

  lzw_stream_encoder #(.DATA_WIDTH(8), .CODE_WIDTH(9), .FULL_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .in_valid(v0), .in_ready(d0_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(d0_valid), .out_ready(r0),
    .out_code(d0_code), .out_last(d0_last), .dict_full(d0_full), .busy(d0_busy)
  );

  lzw_stream_encoder #(.DATA_WIDTH(2), .CODE_WIDTH(3), .FULL_MODE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .in_valid(v1), .in_ready(d1_ready),
    .in_data(in_data[1:0]), .in_last(in_last), .out_valid(d1_valid), .out_ready(r1),
    .out_code(d1_code), .out_last(d1_last), .dict_full(d1_full), .busy(d1_busy)
  );

  lzw_stream_encoder #(.DATA_WIDTH(2), .CODE_WIDTH(3), .FULL_MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .in_valid(v2), .in_ready(d2_ready),
    .in_data(in_data[1:0]), .in_last(in_last), .out_valid(d2_valid), .out_ready(r2),
    .out_code(d2_code), .out_last(d2_last), .dict_full(d2_full), .busy(d2_busy)
  );

  logic       o_valid, o_last, o_full, o_busy, i_ready;
  logic [8:0] o_code;

  always_comb begin
    o_valid = d0_valid; o_code = d0_code; o_last = d0_last;
    o_full  = d0_full;  o_busy = d0_busy; i_ready = d0_ready;
    case (sel)
      2'd1: begin
        o_valid = d1_valid; o_code = {6'b0, d1_code}; o_last = d1_last;
        o_full  = d1_full;  o_busy = d1_busy; i_ready = d1_ready;
      end
      2'd2: begin
        o_valid = d2_valid; o_code = {6'b0, d2_code}; o_last = d2_last;
        o_full  = d2_full;  o_busy = d2_busy; i_ready = d2_ready;
      end
      default: ;
    endcase
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_out    = 0;
  logic       took_in  = 1'b0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [8:0] code, input logic last);
    exp_q.push_back({last, code});
  endtask

  // One clock: sample handshakes at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    logic [9:0] e;
    @(negedge clk);
    took_in = in_valid && i_ready;
    if (o_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_code", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("out_code", 32'(o_code), 32'(e[8:0]));
        check("out_last", 32'(o_last), 32'(e[9]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      ok = took_in;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick();
      done = (exp_q.size() == 0) && !o_busy;
    end
    if (!done) check("idle_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_outs(input int k);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick();
      done = (n_out >= k);
    end
    if (!done) check("out_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_valid();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = o_valid;
    end
    if (!done) check("valid_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_abababa();
    send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h41, 1'b0); send(8'h42, 1'b0);
    send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h41, 1'b1);
  endtask

  initial begin
    int base;
    sel = 2'd0; cs = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    out_ready = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_out_valid", 32'(o_valid), 32'd0);
    check("rst_out_code", 32'(o_code), 32'd0);
    check("rst_out_last", 32'(o_last), 32'd0);
    check("rst_dict_full", 32'(o_full), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_in_ready_cs1", 32'(i_ready), 32'd1);
    cs = 1'b0;
    #1;
    check("rst_in_ready_cs0", 32'(i_ready), 32'd0);
    check("rst_next_code", 32'(dut0.next_code), 32'd256);
    cs = 1'b1;
    rst_n = 1'b1;
    tick();

    // ABABABA -> 65 66 256 258(last)
    push(9'd65, 1'b0); push(9'd66, 1'b0); push(9'd256, 1'b0); push(9'd258, 1'b1);
    send_abababa();
    wait_idle();
    check("abababa_next_code", 32'(dut0.next_code), 32'd256);
    check("abababa_full", 32'(o_full), 32'd0);

    // Single symbol with last
    push(9'd65, 1'b1);
    send(8'h41, 1'b1);
    check("single_valid", 32'(o_valid), 32'd1);
    check("single_code", 32'(o_code), 32'd65);
    check("single_last", 32'(o_last), 32'd1);
    check("single_in_ready", 32'(i_ready), 32'd0);
    base = n_out;
    wait_outs(base + 1);
    check("single_busy_after", 32'(o_busy), 32'd0);
    check("single_valid_after", 32'(o_valid), 32'd0);
    check("single_next_code", 32'(dut0.next_code), 32'd256);

    // Two ABAB messages back to back; dictionary clears between them
    for (int m = 0; m < 2; m++) begin
      push(9'd65, 1'b0); push(9'd66, 1'b0); push(9'd256, 1'b1);
      send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h41, 1'b0); send(8'h42, 1'b1);
      wait_idle();
      check("abab_next_code", 32'(dut0.next_code), 32'd256);
    end

    // Backpressure on the first EMIT, with cs dropped partway through
    push(9'd65, 1'b0); push(9'd66, 1'b0); push(9'd256, 1'b1);
    out_ready = 1'b0;
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_code", 32'(o_code), 32'd65);
      check("hold_last", 32'(o_last), 32'd0);
      check("hold_in_ready", 32'(i_ready), 32'd0);
      if (i == 2) cs = 1'b0;
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h41;
    for (int i = 0; i < 3; i++) tick();
    check("cs_block_ready", 32'(i_ready), 32'd0);
    check("cs_block_busy", 32'(o_busy), 32'd1);
    in_valid = 1'b0;
    cs = 1'b1;
    send(8'h41, 1'b0);
    send(8'h42, 1'b1);
    wait_idle();

    // Reset during SEARCH aborts the message
    push(9'd65, 1'b0); push(9'd66, 1'b0);
    send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h41, 1'b0); send(8'h42, 1'b0);
    send(8'h41, 1'b0);
    check("pre_abort_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #2;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_valid", 32'(o_valid), 32'd0);
    check("abort_next_code", 32'(dut0.next_code), 32'd256);
    check("abort_codes_drained", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b1;
    tick();
    push(9'd65, 1'b0); push(9'd66, 1'b0); push(9'd256, 1'b0); push(9'd258, 1'b1);
    send_abababa();
    wait_idle();

    // 2/3-bit, freeze when full: 0 1 2 3 0 2 1 7 0(last)
    sel = 2'd1;
    tick();
    push(9'd0, 1'b0); push(9'd1, 1'b0); push(9'd2, 1'b0); push(9'd3, 1'b0); push(9'd0, 1'b0);
    push(9'd2, 1'b0); push(9'd1, 1'b0); push(9'd7, 1'b0); push(9'd0, 1'b1);
    base = n_out;
    check("fm0_full_start", 32'(o_full), 32'd0);
    send(8'd0, 1'b0); send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd0, 1'b0);
    wait_outs(base + 4);
    check("fm0_full_rise", 32'(o_full), 32'd1);
    send(8'd2, 1'b0);
    wait_outs(base + 5);
    check("fm0_full_frozen", 32'(o_full), 32'd1);
    check("fm0_next_code", 32'(dut1.next_code), 32'd8);
    send(8'd1, 1'b0); send(8'd3, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b1);
    wait_idle();
    check("fm0_full_after_msg", 32'(o_full), 32'd0);

    // 2/3-bit, restart when full: 0 1 2 3 0 2 1 3 0 0(last)
    sel = 2'd2;
    tick();
    push(9'd0, 1'b0); push(9'd1, 1'b0); push(9'd2, 1'b0); push(9'd3, 1'b0); push(9'd0, 1'b0);
    push(9'd2, 1'b0); push(9'd1, 1'b0); push(9'd3, 1'b0); push(9'd0, 1'b0); push(9'd0, 1'b1);
    base = n_out;
    send(8'd0, 1'b0); send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd0, 1'b0);
    wait_outs(base + 4);
    check("fm1_full_rise", 32'(o_full), 32'd1);
    send(8'd2, 1'b0);
    wait_outs(base + 5);
    check("fm1_full_fall", 32'(o_full), 32'd0);
    check("fm1_next_code", 32'(dut2.next_code), 32'd4);
    send(8'd1, 1'b0); send(8'd3, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b1);
    wait_outs(base + 9);
    check("fm1_full_refill", 32'(o_full), 32'd1);
    wait_idle();
    check("fm1_full_after_msg", 32'(o_full), 32'd0);
    check("all_codes_seen", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lzw_stream_encoder.md
# lzw_stream_encoder

Streaming, parametrised LZW encoder for the tokeniser front end. It accepts one symbol per handshake and emits variable-content, fixed-width codes over a valid/ready output port. Its dictionary holds (prefix code, suffix symbol) pairs and is searched one entry per cycle. It supersedes the RAM-to-RAM encoder with generic symbol/code widths, streaming handshakes, message framing and a selectable dictionary-full policy.

## Interface
- DATA_WIDTH, 8, symbol width; literal codes are 0 .. 2^DATA_WIDTH-1.
- CODE_WIDTH, 9, output code width; dictionary codes are FIRST=2^DATA_WIDTH .. 2^CODE_WIDTH-1; must be > DATA_WIDTH.
- FULL_MODE, 0, 0 = freeze dictionary when full; 1 = reset dictionary when full.

- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  chip select; low blocks acceptance of new symbols.
- in_valid  in  1  symbol valid.
- in_ready  out  1  symbol accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  symbol.
- in_last  in  1  last symbol of message.
- out_valid  out  1  code valid.
- out_ready  in  1  consumer ready.
- out_code  out  CODE_WIDTH  emitted code.
- out_last  out  1  final code of message.
- dict_full  out  1  next_code == 2^CODE_WIDTH.
- busy  out  1  state != IDLE.

## Operation
- Registers:
  - w (current prefix code);
  - c (pending symbol);
  - next_code (FIRST at reset);
  - idx (search pointer);
  - pend_last;
  - dictionary arrays prefix[] and suffix[] for codes FIRST .. 2^CODE_WIDTH-1.
- States: IDLE, WAIT_CHAR, SEARCH, EMIT, FINAL.
- in_ready = cs && (state == IDLE || state == WAIT_CHAR).
- IDLE, on accept: w = in_data (zero-extended). If in_last, go to FINAL; else go to WAIT_CHAR.
- WAIT_CHAR, on accept: c = in_data, pend_last = in_last, idx = FIRST, go to SEARCH.
- SEARCH, one cycle per idx:
  - idx < next_code and prefix[idx] == w and suffix[idx] == c: hit. Set w = idx. If pend_last, go to FINAL; else go to WAIT_CHAR.
  - idx < next_code, no match: idx++.
  - idx == next_code: miss, go to EMIT.
- EMIT: out_valid = 1, out_code = w, out_last = 0. On out_ready:
  - If not full, write prefix[next_code] = w, suffix[next_code] = c, and increment next_code.
  - If full and FULL_MODE = 1, set next_code = FIRST with no insert.
  - If full and FULL_MODE = 0, no change.
  - Then w = c. If pend_last, go to FINAL; else go to WAIT_CHAR.
- FINAL: out_valid = 1, out_code = w, out_last = 1. On out_ready: next_code = FIRST (each message is encoded independently), pend_last = 0, go to IDLE.
- Decoder contract: it mirrors the insert, freeze and reset rules exactly.

## Timing
- Reset (async, rst_n low):
  - state = IDLE, next_code = FIRST, w = 0, c = 0, pend_last = 0.
  - out_valid = 0, out_code = 0, out_last = 0, dict_full = 0, busy = 0.
  - in_ready = cs.
  - Dictionary array contents are don't-care; validity is defined by next_code only.
- Per-symbol latency: 1 accept cycle, plus (hit position − FIRST + 1) cycles for a hit, or (next_code − FIRST + 1) cycles for a miss, plus ≥1 cycle in EMIT.
- out_valid, out_code and out_last are stable until out_ready. They never drop without a handshake, and cs does not affect them.
- cs low freezes IDLE and WAIT_CHAR only. SEARCH, EMIT and FINAL continue.
- An empty dictionary (next_code == FIRST) takes a miss after one SEARCH cycle.
- dict_full is combinational from next_code and updates the cycle after the insert or reset.
- Reset mid-message aborts it: no partial code is emitted and the dictionary is empty.

## Test plan
- Default params, message A B A B A B A (0x41, 0x42, …), last on the final A: codes 65, 66, 256, 258. out_last set only on 258. next_code is 256 after the FINAL handshake.
- Single symbol 0x41 with in_last: code 65 with out_last = 1. busy is low the cycle after the handshake. No insert.
- Two messages "ABAB" (last on the final B) back to back: each emits 65, 66, 256(last). The second message produces no code 257 because the dictionary cleared.
- Hold out_ready low 5 cycles on the first EMIT of "ABAB": out_code is held at 65 with out_valid high and in_ready = 0 throughout. The output then completes normally.
- DATA_WIDTH = 2, CODE_WIDTH = 3, input 0,1,2,3,0,2,1,3,0,0:
  - The first 4 misses fill codes 4–7 and dict_full rises.
  - FULL_MODE = 0: later codes stay ≤ 7 and nothing is inserted.
  - FULL_MODE = 1: the next miss emit sets next_code = 4 and dict_full falls.
- Pulse rst_n low during SEARCH of "ABABABA", then resend the full message: outputs are exactly 65, 66, 256, 258(last).
